// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler: two-requester round-robin digit buffer with a time-shared hex-to-seven-segment refresh.
// Ports: CLOCK_50/RESET_N clock and async active-low reset.
//   A_REQ/A_ADDR/A_DATA -> A_ACK, and the same for B: write {blank,dp,value} into digit ADDR; ACK pulses one cycle.
//   HEX0..HEX5: registered active-low segments {dp,g,f,e,d,c,b,a}.
//   REFRESH_IDX: the digit the sequencer refreshes next.
module hex_display_scheduler #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       A_REQ,
  input  logic [2:0] A_ADDR,
  input  logic [5:0] A_DATA,
  output logic       A_ACK,
  input  logic       B_REQ,
  input  logic [2:0] B_ADDR,
  input  logic [5:0] B_DATA,
  output logic       B_ACK,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5,
  output logic [2:0] REFRESH_IDX
);
  typedef enum logic [1:0] {IDLE, ENCODE, LOAD} state_t;
  localparam logic [19:0] DIV_LAST = 20'(REFRESH_DIV - 1);
  state_t      r_state, w_next;
  logic [5:0]  r_buf [6];
  logic [7:0]  r_hex [6];
  logic [5:0]  r_enc;
  logic [19:0] r_div;
  logic [2:0]  r_idx;
  logic        r_a_ack, r_b_ack, r_ptr;
  logic        w_ea, w_eb, w_ga, w_gb, w_tick;
  logic [7:0]  w_digit, w_seg;
  // r_ptr = 0 favours A; a requester sits out its own ACK cycle.
  assign w_ea = A_REQ & ~r_a_ack;
  assign w_eb = B_REQ & ~r_b_ack;
  assign w_ga = w_ea & (~w_eb | ~r_ptr);
  assign w_gb = w_eb & (~w_ea | r_ptr);
  assign w_tick = r_div == DIV_LAST;
  always_comb begin
    w_digit = 8'hFF;
    case (r_enc[3:0])
      4'h0: w_digit = 8'hC0;
      4'h1: w_digit = 8'hF9;
      4'h2: w_digit = 8'hA4;
      4'h3: w_digit = 8'hB0;
      4'h4: w_digit = 8'h99;
      4'h5: w_digit = 8'h92;
      4'h6: w_digit = 8'h82;
      4'h7: w_digit = 8'hF8;
      4'h8: w_digit = 8'h80;
      4'h9: w_digit = 8'h90;
      4'hA: w_digit = 8'h88;
      4'hB: w_digit = 8'h83;
      4'hC: w_digit = 8'hC6;
      4'hD: w_digit = 8'hA1;
      4'hE: w_digit = 8'h86;
      4'hF: w_digit = 8'h8E;
      default: w_digit = 8'hFF;
    endcase
  end
  assign w_seg = r_enc[5] ? 8'hFF : {w_digit[7] & ~r_enc[4], w_digit[6:0]};
  always_comb w_next = r_state == ENCODE ? LOAD : (r_state == IDLE && w_tick) ? ENCODE : IDLE;
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      for (int i = 0; i < 6; i++) begin
        r_buf[i] <= 6'b100000;
        r_hex[i] <= 8'hFF;
      end
      r_enc   <= 6'b100000;
      r_div   <= '0;
      r_idx   <= '0;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_ptr   <= 1'b0;
    end else begin
      r_a_ack <= w_ga;
      r_b_ack <= w_gb;
      if (w_ea && w_eb) r_ptr <= ~r_ptr;
      r_div <= w_tick ? '0 : r_div + 20'd1;
      for (int i = 0; i < 6; i++)
        if (w_ga && A_ADDR == 3'(i)) r_buf[i] <= A_DATA;
        else if (w_gb && B_ADDR == 3'(i)) r_buf[i] <= B_DATA;
      // The encoder input is latched so later buffer writes cannot disturb the pending LOAD.
      if (r_state == ENCODE)
        for (int i = 0; i < 6; i++)
          if (r_idx == 3'(i)) r_enc <= r_buf[i];
      if (r_state == LOAD) begin
        for (int i = 0; i < 6; i++)
          if (r_idx == 3'(i)) r_hex[i] <= w_seg;
        r_idx <= r_idx == 3'd5 ? 3'd0 : r_idx + 3'd1;
      end
    end
  assign A_ACK = r_a_ack;
  assign B_ACK = r_b_ack;
  assign REFRESH_IDX = r_idx;
  assign HEX0 = r_hex[0];
  assign HEX1 = r_hex[1];
  assign HEX2 = r_hex[2];
  assign HEX3 = r_hex[3];
  assign HEX4 = r_hex[4];
  assign HEX5 = r_hex[5];
endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb_hex_display_scheduler: randomized self-checking bench against a digit-buffer reference model.
module tb_hex_display_scheduler;
  localparam int N = 4;
  localparam int SWEEP = 6 * N + 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a_req = 1'b0, b_req = 1'b0;
  logic [2:0] a_addr = '0, b_addr = '0;
  logic [5:0] a_data = '0, b_data = '0;
  logic a_ack, b_ack;
  logic [7:0] h0, h1, h2, h3, h4, h5;
  logic [2:0] idx;
  wire  [7:0] hx [6];
  int checks = 0, errors = 0;
  logic [5:0] model [6];
  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  assign hx[0] = h0;
  assign hx[1] = h1;
  assign hx[2] = h2;
  assign hx[3] = h3;
  assign hx[4] = h4;
  assign hx[5] = h5;
  hex_display_scheduler #(.REFRESH_DIV(N)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .A_REQ(a_req), .A_ADDR(a_addr), .A_DATA(a_data), .A_ACK(a_ack),
    .B_REQ(b_req), .B_ADDR(b_addr), .B_DATA(b_data), .B_ACK(b_ack),
    .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5),
    .REFRESH_IDX(idx)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic logic [7:0] enc(input logic [5:0] e);
    logic [7:0] p;
    p = seg_tbl[e[3:0]];
    if (e[4]) p[7] = 1'b0;
    return e[5] ? 8'hFF : p;
  endfunction
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 6; i++) model[i] = 6'b100000;
  endtask
  task automatic write_req(input bit who, input logic [2:0] addr, input logic [5:0] data,
                           output int lat, output bit again);
    lat = -1;
    if (who) begin b_req = 1'b1; b_addr = addr; b_data = data; end
    else begin a_req = 1'b1; a_addr = addr; a_data = data; end
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if ((who ? b_ack : a_ack) === 1'b1) begin
        lat = i + 1;
        break;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    cyc(1);
    again = (who ? b_ack : a_ack) !== 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    cyc(2);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hx[i] !== 8'hFF) begin errors++; $display("FAIL reset_hex%0d: got %h want ff", i, hx[i]); end
    end
    checks++;
    if ({a_ack, b_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {a_ack, b_ack}); end
    checks++;
    if (idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", idx); end
    rst_n = 1'b1;
    cyc(5);
    checks++;
    if (idx !== 3'd0) begin errors++; $display("FAIL first_tick_early: idx %0d want 0", idx); end
    cyc(1);
    checks++;
    if (idx !== 3'd1) begin errors++; $display("FAIL first_load: idx %0d want 1", idx); end
    checks++;
    if (h0 !== 8'hFF) begin errors++; $display("FAIL blank_hex0: got %h want ff", h0); end
    cyc(N);
    checks++;
    if (idx !== 3'd2) begin errors++; $display("FAIL refresh_period: idx %0d want 2", idx); end
  endtask
  task automatic test_single_write();
    int lat;
    bit again;
    write_req(1'b0, 3'd2, 6'b000101, lat, again);
    checks++;
    if (lat != 1 || again) begin errors++; $display("FAIL single_ack: latency %0d repeat %0b want 1 0", lat, again); end
    model[2] = 6'b000101;
    cyc(SWEEP);
    checks++;
    if (h2 !== 8'h92) begin errors++; $display("FAIL single_hex2: got %h want 92", h2); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hx[i] !== enc(model[i])) begin errors++; $display("FAIL single_hex%0d: got %h want %h", i, hx[i], enc(model[i])); end
    end
  endtask
  task automatic test_encoder();
    int lat;
    bit again;
    logic [5:0] d;
    for (int v = 0; v < 18; v++) begin
      d = v < 16 ? 6'(v) : (v == 16 ? 6'b010101 : 6'b101000);
      write_req(1'($urandom_range(0, 1)), 3'd0, d, lat, again);
      checks++;
      if (lat != 1 || again) begin errors++; $display("FAIL enc_ack%0d: latency %0d repeat %0b want 1 0", v, lat, again); end
      model[0] = d;
      cyc(SWEEP);
      checks++;
      if (h0 !== enc(d)) begin errors++; $display("FAIL enc_%02h: got %h want %h", d, h0, enc(d)); end
    end
  endtask
  task automatic test_contention();
    logic [1:0] want;
    a_addr = 3'($urandom_range(0, 5));
    b_addr = 3'((32'(a_addr) + 1 + $urandom_range(0, 4)) % 6);
    a_data = 6'($urandom_range(0, 31));
    b_data = 6'($urandom_range(0, 31));
    a_req = 1'b1;
    b_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      want = k % 2 == 0 ? 2'b10 : 2'b01;
      checks++;
      if ({a_ack, b_ack} !== want) begin errors++; $display("FAIL contend_cyc%0d: acks %b want %b", k, {a_ack, b_ack}, want); end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    model[a_addr] = a_data;
    model[b_addr] = b_data;
    cyc(1);
    checks++;
    if ({a_ack, b_ack} !== 2'b00) begin errors++; $display("FAIL contend_stop: acks %b want 00", {a_ack, b_ack}); end
    a_req = 1'b1;
    b_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      want = k == 0 ? 2'b01 : 2'b10;
      checks++;
      if ({a_ack, b_ack} !== want) begin errors++; $display("FAIL contend_ptr%0d: acks %b want %b", k, {a_ack, b_ack}, want); end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    cyc(SWEEP);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hx[i] !== enc(model[i])) begin errors++; $display("FAIL contend_hex%0d: got %h want %h", i, hx[i], enc(model[i])); end
    end
  endtask
  task automatic test_random();
    int lat;
    bit again;
    logic [2:0] ad;
    logic [5:0] d;
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 6; w++) begin
        ad = 3'($urandom_range(0, 7));
        d = 6'($urandom_range(0, 63));
        write_req(1'($urandom_range(0, 1)), ad, d, lat, again);
        checks++;
        if (lat != 1 || again) begin errors++; $display("FAIL rand_ack%0d_%0d: latency %0d repeat %0b want 1 0", r, w, lat, again); end
        if (ad < 3'd6) model[ad] = d;
      end
      cyc(SWEEP);
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (hx[i] !== enc(model[i])) begin errors++; $display("FAIL rand%0d_hex%0d: got %h want %h", r, i, hx[i], enc(model[i])); end
      end
    end
  endtask
  task automatic test_invalid_addr();
    int lat;
    bit again;
    write_req(1'b1, 3'd7, 6'($urandom_range(0, 31)), lat, again);
    checks++;
    if (lat != 1 || again) begin errors++; $display("FAIL invalid_ack: latency %0d repeat %0b want 1 0", lat, again); end
    write_req(1'b0, 3'd6, 6'($urandom_range(0, 31)), lat, again);
    checks++;
    if (lat != 1 || again) begin errors++; $display("FAIL invalid6_ack: latency %0d repeat %0b want 1 0", lat, again); end
    cyc(SWEEP);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hx[i] !== enc(model[i])) begin errors++; $display("FAIL invalid_hex%0d: got %h want %h", i, hx[i], enc(model[i])); end
    end
  endtask
  task automatic test_reset_mid();
    logic [2:0] prev;
    bit seen;
    prev = idx;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (idx !== prev) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_sync: refresh index stuck at %0d", idx); end
    cyc(2);
    a_req = 1'b1;
    a_addr = 3'($urandom_range(0, 5));
    a_data = 6'($urandom_range(0, 31));
    cyc(1);
    checks++;
    if (a_ack !== 1'b1) begin errors++; $display("FAIL mid_ack_before: got %b want 1", a_ack); end
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hx[i] !== 8'hFF) begin errors++; $display("FAIL mid_reset_hex%0d: got %h want ff", i, hx[i]); end
    end
    checks++;
    if ({a_ack, b_ack, idx} !== 5'b0) begin errors++; $display("FAIL mid_reset_ctl: acks %b idx %0d want 00 0", {a_ack, b_ack}, idx); end
    cyc(2);
    checks++;
    if (a_ack !== 1'b0) begin errors++; $display("FAIL mid_held_in_reset: ack %b want 0", a_ack); end
    rst_n = 1'b1;
    cyc(1);
    checks++;
    if (a_ack !== 1'b1) begin errors++; $display("FAIL mid_regrant: ack %b want 1", a_ack); end
    a_req = 1'b0;
    model[a_addr] = a_data;
    cyc(SWEEP);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hx[i] !== enc(model[i])) begin errors++; $display("FAIL mid_hex%0d: got %h want %h", i, hx[i], enc(model[i])); end
    end
  endtask
  initial begin
    cyc(1);
    test_reset();
    test_single_write();
    test_encoder();
    test_contention();
    test_random();
    test_invalid_addr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hex_display_scheduler.md
# hex_display_scheduler

Six-digit seven-segment display controller for the board top level. Two requesters (A and B) write digit entries through a round-robin arbitrated req/ack port into a six-entry digit buffer. A refresh sequencer walks the buffer, passing each entry through a single shared hex-to-segment encoder and loading the result into that digit's registered HEX output. It sits between user logic (SW-driven and counter-driven sources) and HEX0–HEX5.

## Interface
- REFRESH_DIV, default 50000: clock cycles between refresh steps; legal range 3 to 2^20-1.
- CLOCK_50  input  1  system clock; all logic on the rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- A_REQ  input  1  requester A write request; held until A_ACK.
- A_ADDR  input  3  requester A digit index; 0–5 valid.
- A_DATA  input  6  requester A entry: {blank, dp, value[3:0]}.
- A_ACK  output  1  one-cycle grant/write acknowledge to A.
- B_REQ, B_ADDR, B_DATA, B_ACK: identical to A for requester B.
- HEX0..HEX5  output  8 each  active-low segment pattern, bit order dp g f e d c b a (MSB first); registered.
- REFRESH_IDX  output  3  digit index currently being refreshed (debug/verification).

## Operation
- Reset values: every buffer entry is {blank=1, dp=0, value=0}; HEX0–HEX5 = 8'hFF; A_ACK = B_ACK = 0; REFRESH_IDX = 0; sequencer in IDLE; divider = 0; round-robin pointer favours A.
- Arbiter: at each rising edge, eligible requesters are those with REQ=1 whose ACK is not currently high.
  - One eligible requester: it is granted.
  - Both eligible: the requester holding the pointer is granted, and the pointer moves to the other requester.
  - A single grant with no contention leaves the pointer unchanged.
- Grant: at that edge, the entry at ADDR is written with DATA and ACK goes high for exactly the next cycle. Addresses 6–7 are acknowledged but cause no write.
- Re-grant rule: a requester is never granted during its own ACK cycle, so it gets at most one write every 2 cycles. With both requesters active, grants alternate every cycle.
- Divider: counts 0..REFRESH_DIV-1 and wraps. The cycle at REFRESH_DIV-1 is a tick. A tick is dropped if the sequencer is not in IDLE.
- Sequencer states:
  - IDLE: on tick, go to ENCODE.
  - ENCODE: latch buffer[REFRESH_IDX] into the encoder input register, then go to LOAD.
  - LOAD: write the encoder output into HEX[REFRESH_IDX], increment REFRESH_IDX (5 wraps to 0), then go to IDLE.
- Encoder, with dp=0 and blank=0:
  - Values 0–9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - Values A–F: 88 83 C6 A1 86 8E.
  - dp=1 clears bit 7 (e.g. 5 with dp gives 12).
  - blank=1 gives FF regardless of value and dp.
- A buffer write to an index between its ENCODE and LOAD does not affect that LOAD. The new value appears on the next sweep.
- RESET_N low at any time, including mid-sweep or during an ACK cycle, immediately forces all reset values. A request held through reset is arbitrated afresh after release.

## Timing
- Write latency: ACK is high in the cycle after the granting edge.
- Display latency: HEX[i] reflects a write within 6*REFRESH_DIV + 2 cycles after ACK.
- First tick occurs REFRESH_DIV cycles after reset release. HEX0 updates 2 cycles after that tick, and HEX[i] updates 2 cycles after the tick for index i.
- One full sweep of all six digits takes 6*REFRESH_DIV cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold RESET_N low, then release → all HEX = FF, both ACKs 0, REFRESH_IDX = 0. With REFRESH_DIV=4, HEX0 stays FF after its first update (blank entry).
- Single write: A writes ADDR=2, DATA=6'b000101 → A_ACK high for one cycle; after one full sweep HEX2 = 92, all other HEX stay FF.
- Contention: A and B both request continuously with distinct addresses → first grant goes to A; grants then alternate B, A, B; no two ACKs are high in the same cycle.
- Encoder and flags: write all values 0–F to digit 0, plus dp=1 on value 5 and blank=1 on value 8 → HEX0 shows the listed patterns, 12 for 5 with dp, and FF for the blanked 8.
- Invalid address: B writes ADDR=7 → B_ACK pulses once; all HEX unchanged after a full sweep.
- Reset mid-operation: assert RESET_N during a LOAD state while A_ACK is high → outputs immediately return to reset values; after release, the held A request is acknowledged again.
